// File: rtl/bp_pkg.sv
// Shared types for the BTB update sequencer.
// Holds the queued-update record, the sweep FSM states and a saturating increment.
package bp_pkg;

  localparam int IDX_LO = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } bp_upd_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } bp_state_e;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO of resolved-branch updates with flush.
// Ports: push/pop/flush, din, head (read-ahead), full, empty; async active-high rst.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  logic    flush,
  input  bp_upd_t din,
  output bp_upd_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  bp_upd_t        mem [DEPTH];
  logic [AW-1:0]  rd;
  logic [AW-1:0]  wr;
  logic [AW:0]    cnt;
  logic           do_push;
  logic           do_pop;

  assign full    = (cnt == CNT_FULL);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd];

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else if (flush) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (do_push)
        wr <= wr + 1'b1;
      if (do_pop)
        rd <= rd + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// EX-stage branch resolution: mispredict/redirect, update queue drain to the
// BTB write port, invalidate sweep FSM and branch/mispredict counters.
module bp_update_ctrl
  import bp_pkg::*;
#(
  parameter int TABLE_LEN  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [31:0]          PCE,
  input  logic                 PredE,
  input  logic [31:0]          NPC_PredE,
  input  logic                 BranchE,
  input  logic [31:0]          BrNPC,
  output logic                 mispredict,
  output logic [31:0]          redirect_pc,
  output logic                 stall_ex,
  input  logic                 inv_req,
  output logic                 inv_busy,
  output logic                 wr_en,
  output logic [TABLE_LEN-1:0] wr_idx,
  output logic [31:0]          wr_tag,
  output logic [31:0]          wr_target,
  output logic                 wr_taken,
  output logic                 wr_clear,
  output logic [31:0]          cnt_branch,
  output logic [31:0]          cnt_mispred
);

  bp_state_e            state;
  logic [TABLE_LEN-1:0] idx;
  logic [31:0]          cnt_br;
  logic [31:0]          cnt_mp;
  bp_upd_t              head;
  bp_upd_t              din;
  logic                 full;
  logic                 empty;
  logic                 push_ok;
  logic                 pop;

  assign din      = '{pc: PCE, target: BrNPC, taken: BranchE};
  assign push_ok  = ex_valid && (BranchE || PredE) && !full;
  assign pop      = (state == IDLE) && !empty;
  assign stall_ex = full;
  assign inv_busy = (state == SWEEP);

  assign cnt_branch  = cnt_br;
  assign cnt_mispred = cnt_mp;

  bp_upd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_ok),
    .pop  (pop),
    .flush(inv_req),
    .din  (din),
    .head (head),
    .full (full),
    .empty(empty)
  );

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = 32'd0;
    if (ex_valid) begin
      if (BranchE && (!PredE || NPC_PredE != BrNPC)) begin
        mispredict  = 1'b1;
        redirect_pc = BrNPC;
      end else if (!BranchE && PredE) begin
        mispredict  = 1'b1;
        redirect_pc = PCE + 32'd4;
      end
    end
  end

  always_comb begin
    wr_en     = 1'b0;
    wr_clear  = 1'b0;
    wr_idx    = '0;
    wr_tag    = 32'd0;
    wr_target = 32'd0;
    wr_taken  = 1'b0;
    unique case (state)
      SWEEP: begin
        wr_en    = 1'b1;
        wr_clear = 1'b1;
        wr_idx   = idx;
      end
      default: begin
        wr_en = !empty;
        if (!empty) begin
          wr_idx    = head.pc[TABLE_LEN+IDX_LO-1:IDX_LO];
          wr_tag    = head.pc;
          wr_target = head.target;
          wr_taken  = head.taken;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      unique case (state)
        SWEEP: begin
          if (inv_req) begin
            idx <= '0;
          end else if (idx == '1) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          if (inv_req) begin
            state <= SWEEP;
            idx   <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_br <= 32'd0;
      cnt_mp <= 32'd0;
    end else if (push_ok) begin
      cnt_br <= sat_inc(cnt_br);
      if (mispredict)
        cnt_mp <= sat_inc(cnt_mp);
    end
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Self-checking bench for bp_update_ctrl: vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_bp_update_ctrl;
  import bp_pkg::*;

  localparam int TL   = 4;
  localparam int FD   = 4;
  localparam int NENT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid;
  logic [31:0]   PCE;
  logic          PredE;
  logic [31:0]   NPC_PredE;
  logic          BranchE;
  logic [31:0]   BrNPC;
  logic          mispredict;
  logic [31:0]   redirect_pc;
  logic          stall_ex;
  logic          inv_req;
  logic          inv_busy;
  logic          wr_en;
  logic [TL-1:0] wr_idx;
  logic [31:0]   wr_tag;
  logic [31:0]   wr_target;
  logic          wr_taken;
  logic          wr_clear;
  logic [31:0]   cnt_branch;
  logic [31:0]   cnt_mispred;

  always #5 clk = ~clk;

  bp_update_ctrl #(
    .TABLE_LEN (TL),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .PCE        (PCE),
    .PredE      (PredE),
    .NPC_PredE  (NPC_PredE),
    .BranchE    (BranchE),
    .BrNPC      (BrNPC),
    .mispredict (mispredict),
    .redirect_pc(redirect_pc),
    .stall_ex   (stall_ex),
    .inv_req    (inv_req),
    .inv_busy   (inv_busy),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_tag     (wr_tag),
    .wr_target  (wr_target),
    .wr_taken   (wr_taken),
    .wr_clear   (wr_clear),
    .cnt_branch (cnt_branch),
    .cnt_mispred(cnt_mispred)
  );

  bp_upd_t     q[$];
  int          sweep_left;
  logic [31:0] m_cb;
  logic [31:0] m_cm;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_mis(output logic mis, output logic [31:0] rd);
    mis = 1'b0;
    rd  = 32'd0;
    if (ex_valid && BranchE && (!PredE || NPC_PredE != BrNPC)) begin
      mis = 1'b1;
      rd  = BrNPC;
    end else if (ex_valid && !BranchE && PredE) begin
      mis = 1'b1;
      rd  = PCE + 32'd4;
    end
  endtask

  task automatic model_check;
    logic        mis;
    logic [31:0] rd;
    logic        e_en, e_clr, e_tk;
    logic [31:0] e_idx, e_tag, e_tgt;
    exp_mis(mis, rd);
    e_en = 0; e_clr = 0; e_tk = 0;
    e_idx = 0; e_tag = 0; e_tgt = 0;
    if (sweep_left > 0) begin
      e_en  = 1;
      e_clr = 1;
      e_idx = NENT - sweep_left;
    end else if (q.size() > 0) begin
      e_en  = 1;
      e_idx = (q[0].pc >> 2) % NENT;
      e_tag = q[0].pc;
      e_tgt = q[0].target;
      e_tk  = q[0].taken;
    end
    chk("mispredict", {31'd0, mispredict}, {31'd0, mis});
    chk("redirect_pc", redirect_pc, rd);
    chk("stall_ex", {31'd0, stall_ex}, {31'd0, q.size() == FD});
    chk("inv_busy", {31'd0, inv_busy}, {31'd0, sweep_left > 0});
    chk("wr_en", {31'd0, wr_en}, {31'd0, e_en});
    chk("wr_clear", {31'd0, wr_clear}, {31'd0, e_clr});
    chk("wr_idx", {28'd0, wr_idx}, e_idx);
    chk("wr_tag", wr_tag, e_tag);
    chk("wr_target", wr_target, e_tgt);
    chk("wr_taken", {31'd0, wr_taken}, {31'd0, e_tk});
    chk("cnt_branch", cnt_branch, m_cb);
    chk("cnt_mispred", cnt_mispred, m_cm);
  endtask

  task automatic drive(input logic ev, input logic [31:0] pce,
                       input logic pred, input logic [31:0] npc,
                       input logic br, input logic [31:0] brnpc,
                       input logic inv);
    ex_valid  = ev;
    PCE       = pce;
    PredE     = pred;
    NPC_PredE = npc;
    BranchE   = br;
    BrNPC     = brnpc;
    inv_req   = inv;
    #1;
    model_check();
  endtask

  task automatic tick;
    logic        mis, acc, busy;
    logic [31:0] rd;
    bp_upd_t     e;
    exp_mis(mis, rd);
    acc  = ex_valid && (BranchE || PredE) && (q.size() < FD);
    busy = sweep_left > 0;
    e    = '{pc: PCE, target: BrNPC, taken: BranchE};
    @(posedge clk);
    if (acc) begin
      if (m_cb != 32'hFFFF_FFFF) m_cb = m_cb + 1;
      if (mis && m_cm != 32'hFFFF_FFFF) m_cm = m_cm + 1;
    end
    if (!busy && q.size() > 0)
      void'(q.pop_front());
    if (inv_req) begin
      q.delete();
      sweep_left = NENT;
    end else begin
      if (busy) sweep_left--;
      if (acc) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1; ex_valid = 0; PCE = 0; PredE = 0;
    NPC_PredE = 0; BranchE = 0; BrNPC = 0; inv_req = 0;
    #1;
    q.delete();
    sweep_left = 0;
    m_cb = 0;
    m_cm = 0;
    model_check();
    @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    logic        ev;
    logic [31:0] pce;
    logic        pred;
    logic [31:0] npc;
    logic        br;
    logic [31:0] brnpc;
    logic        mis;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[8];

  initial begin
    int n, busy_n, stray;
    bit done;
    vt[0] = '{1, 32'h100, 0, 32'h0,   1, 32'h200, 1, 32'h200};
    vt[1] = '{1, 32'h104, 1, 32'h300, 1, 32'h300, 0, 32'h0};
    vt[2] = '{1, 32'h108, 1, 32'h300, 1, 32'h304, 1, 32'h304};
    vt[3] = '{1, 32'h10C, 1, 32'h400, 0, 32'h110, 1, 32'h110};
    vt[4] = '{1, 32'h110, 0, 32'h0,   0, 32'h114, 0, 32'h0};
    vt[5] = '{0, 32'h114, 0, 32'h0,   1, 32'h500, 0, 32'h0};
    vt[6] = '{1, 32'hFFFF_FFFC, 1, 32'h8, 0, 32'h0, 1, 32'h0};
    vt[7] = '{0, 32'h120, 1, 32'h9,   0, 32'h124, 0, 32'h0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].ev, vt[i].pce, vt[i].pred, vt[i].npc,
            vt[i].br, vt[i].brnpc, 0);
      chk("vec_mis", {31'd0, mispredict}, {31'd0, vt[i].mis});
      chk("vec_redir", redirect_pc, vt[i].rd);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
    end

    // T1
    do_reset();
    drive(1, 32'h40, 0, 0, 1, 32'h80, 0);
    chk("t1_mis", {31'd0, mispredict}, 32'd1);
    chk("t1_redir", redirect_pc, 32'h80);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t1_wr_en", {31'd0, wr_en}, 32'd1);
    chk("t1_wr_idx", {28'd0, wr_idx}, 32'd0);
    chk("t1_wr_tag", wr_tag, 32'h40);
    chk("t1_wr_taken", {31'd0, wr_taken}, 32'd1);
    chk("t1_cnt_mp", cnt_mispred, 32'd1);
    tick();

    // T2
    drive(1, 32'h44, 1, 32'h90, 0, 32'h48, 0);
    chk("t2_mis", {31'd0, mispredict}, 32'd1);
    chk("t2_redir", redirect_pc, 32'h48);
    tick();
    drive(1, 32'h48, 1, 32'h90, 1, 32'h90, 0);
    chk("t2_mis_ok", {31'd0, mispredict}, 32'd0);
    chk("t2_wr_tag", wr_tag, 32'h44);
    chk("t2_wr_taken", {31'd0, wr_taken}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // T3
    do_reset();
    drive(1, 32'h40, 0, 0, 1, 32'h80, 0);
    tick();
    drive(1, 32'h60, 0, 0, 1, 32'h88, 1);
    tick();
    busy_n = 0;
    stray  = 0;
    for (int i = 0; i < 22; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      if (inv_busy) begin
        chk("t3_idx", {28'd0, wr_idx}, busy_n);
        busy_n++;
      end else if (wr_en) begin
        stray++;
      end
      tick();
    end
    chk("t3_busy_cycles", busy_n, 32'd16);
    chk("t3_stray_writes", stray, 32'd0);

    // T4
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h200 + 4 * i, 0, 0, 1, 32'h1000 + i, 0);
      tick();
    end
    drive(1, 32'h210, 0, 0, 1, 32'h2000, 0);
    chk("t4_stall", {31'd0, stall_ex}, 32'd1);
    chk("t4_cnt_br", cnt_branch, 32'd4);
    tick();
    done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      if (!inv_busy) done = 1;
      else tick();
    end
    chk("t4_sweep_end", {31'd0, done}, 32'd1);
    n = 0;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) drive(0, 0, 0, 0, 0, 0, 0);
      if (wr_en && !wr_clear) n++;
      tick();
    end
    chk("t4_drained", n, 32'd4);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t4_stall_drop", {31'd0, stall_ex}, 32'd0);
    tick();

    // T5
    do_reset();
    drive(1, 32'h40, 1, 32'h44, 0, 32'h44, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      if (inv_busy && wr_idx == 4'd7) done = 1;
      else tick();
    end
    chk("t5_reach7", {31'd0, done}, 32'd1);
    rst = 1;
    #1;
    chk("t5_wr_en", {31'd0, wr_en}, 32'd0);
    chk("t5_busy", {31'd0, inv_busy}, 32'd0);
    chk("t5_cnt_br", cnt_branch, 32'd0);
    chk("t5_cnt_mp", cnt_mispred, 32'd0);
    do_reset();

    // T6
    drive(0, 0, 0, 0, 0, 0, 0);
    force dut.cnt_br = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_br;
    m_cb = 32'hFFFF_FFFF;
    drive(1, 32'h40, 0, 0, 1, 32'h80, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t6_sat", cnt_branch, 32'hFFFF_FFFF);
    chk("t6_cnt_mp", cnt_mispred, 32'd1);
    tick();

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc, np, bn;
      pc = $urandom() & 32'hFFFF_FFFC;
      np = $urandom() & 32'hFFFF_FFFC;
      bn = ($urandom_range(0, 1) == 1) ? np : ($urandom() & 32'hFFFF_FFFC);
      drive(1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)), np,
            1'($urandom_range(0, 1)), bn, ($urandom_range(0, 39) == 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
